// File: rtl/bullet_renderer.sv
// bullet_renderer: turns bullet position updates into VGA pixel writes.
// Optional build macro BULLET_RENDER_CLIP_EN suppresses off-screen pixels.
module bullet_renderer #(
    parameter int          SIZE      = 2,
    parameter logic [2:0]  FG_COLOUR = 3'b111,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] bullet_x,
    input  logic [6:0] bullet_y,
    input  logic       plot_bullet,
    input  logic       firing,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} state_t;

    localparam logic [1:0] LAST = 2'(SIZE - 1);

`ifdef BULLET_RENDER_CLIP_EN
    localparam int XW = 9;
    localparam int YW = 8;
`else
    localparam int XW = 8;
    localparam int YW = 7;
`endif

    state_t     state, state_n;
    logic [1:0] px, px_n, py, py_n;
    logic [7:0] prev_x, prev_x_n, tgt_x, tgt_x_n, pend_x, pend_x_n;
    logic [6:0] prev_y, prev_y_n, tgt_y, tgt_y_n, pend_y, pend_y_n;
    logic       have_prev, have_prev_n;
    logic       draw_after, draw_after_n;
    logic       pend_valid, pend_valid_n;
    logic       pend_erase, pend_erase_n;
    logic       fire_q;
    logic       fire_fall;
    logic       last_px;

    logic [7:0]    base_x;
    logic [6:0]    base_y;
    logic [XW-1:0] x_sum;
    logic [YW-1:0] y_sum;
    logic [7:0]    vga_x_d;
    logic [6:0]    vga_y_d;
    logic [2:0]    colour_d;
    logic          plot_d, busy_d, done_d;

    assign fire_fall = fire_q & ~firing;
    assign last_px   = (px == LAST) && (py == LAST);

    // Next-state: dispatch, sprite walk, and request capture
    always_comb begin
        state_n      = state;
        px_n         = px;
        py_n         = py;
        prev_x_n     = prev_x;
        prev_y_n     = prev_y;
        tgt_x_n      = tgt_x;
        tgt_y_n      = tgt_y;
        have_prev_n  = have_prev;
        draw_after_n = draw_after;
        pend_x_n     = pend_x;
        pend_y_n     = pend_y;
        pend_valid_n = pend_valid;
        pend_erase_n = pend_erase;
        unique case (state)
            IDLE: begin
                if (pend_erase) begin
                    pend_erase_n = 1'b0;
                    if (have_prev) begin
                        state_n      = ERASE;
                        draw_after_n = 1'b0;
                        px_n         = 2'd0;
                        py_n         = 2'd0;
                    end
                end else if (pend_valid) begin
                    pend_valid_n = 1'b0;
                    tgt_x_n      = pend_x;
                    tgt_y_n      = pend_y;
                    draw_after_n = 1'b1;
                    px_n         = 2'd0;
                    py_n         = 2'd0;
                    state_n      = have_prev ? ERASE : DRAW;
                end
            end
            ERASE, DRAW: begin
                if (last_px) begin
                    px_n = 2'd0;
                    py_n = 2'd0;
                    if (state == DRAW) begin
                        prev_x_n    = tgt_x;
                        prev_y_n    = tgt_y;
                        have_prev_n = 1'b1;
                        state_n     = FINISH;
                    end else if (draw_after) begin
                        state_n = DRAW;
                    end else begin
                        have_prev_n = 1'b0;
                        state_n     = FINISH;
                    end
                end else if (px == LAST) begin
                    px_n = 2'd0;
                    py_n = py + 2'd1;
                end else begin
                    px_n = px + 2'd1;
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (plot_bullet) begin
            pend_valid_n = 1'b1;
            pend_x_n     = bullet_x;
            pend_y_n     = bullet_y;
        end
        if (fire_fall) begin
            pend_valid_n = 1'b0;
            pend_erase_n = 1'b1;
        end
    end

    // Next outputs: pixel for the upcoming cycle so writes start right after dispatch
    always_comb begin
        base_x   = (state_n == ERASE) ? prev_x : tgt_x_n;
        base_y   = (state_n == ERASE) ? prev_y : tgt_y_n;
        x_sum    = XW'(base_x) + XW'(px_n);
        y_sum    = YW'(base_y) + YW'(py_n);
        vga_x_d  = vga_x;
        vga_y_d  = vga_y;
        colour_d = vga_colour;
        plot_d   = 1'b0;
        if (state_n == ERASE || state_n == DRAW) begin
            vga_x_d  = x_sum[7:0];
            vga_y_d  = y_sum[6:0];
            colour_d = (state_n == ERASE) ? BG_COLOUR : FG_COLOUR;
`ifdef BULLET_RENDER_CLIP_EN
            plot_d   = (x_sum < 9'd160) && (y_sum < 8'd120);
`else
            plot_d   = 1'b1;
`endif
        end
        busy_d = (state_n != IDLE);
        done_d = (state_n == FINISH);
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            px         <= 2'd0;
            py         <= 2'd0;
            prev_x     <= 8'd0;
            prev_y     <= 7'd0;
            tgt_x      <= 8'd0;
            tgt_y      <= 7'd0;
            have_prev  <= 1'b0;
            draw_after <= 1'b0;
            pend_x     <= 8'd0;
            pend_y     <= 7'd0;
            pend_valid <= 1'b0;
            pend_erase <= 1'b0;
            fire_q     <= 1'b0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            px         <= px_n;
            py         <= py_n;
            prev_x     <= prev_x_n;
            prev_y     <= prev_y_n;
            tgt_x      <= tgt_x_n;
            tgt_y      <= tgt_y_n;
            have_prev  <= have_prev_n;
            draw_after <= draw_after_n;
            pend_x     <= pend_x_n;
            pend_y     <= pend_y_n;
            pend_valid <= pend_valid_n;
            pend_erase <= pend_erase_n;
            fire_q     <= firing;
            vga_x      <= vga_x_d;
            vga_y      <= vga_y_d;
            vga_colour <= colour_d;
            vga_plot   <= plot_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_bullet_renderer.sv
// tb_bullet_renderer: directed plus random stimulus against a
// transaction-level model that schedules expected pixel writes per cycle.
module tb_bullet_renderer;

    localparam int SIZE = 2;

    logic       clk;
    logic       resetn;
    logic [7:0] bullet_x;
    logic [6:0] bullet_y;
    logic       plot_bullet;
    logic       firing;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    bullet_renderer #(
        .SIZE      (SIZE),
        .FG_COLOUR (3'b111),
        .BG_COLOUR (3'b000)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bullet_x    (bullet_x),
        .bullet_y    (bullet_y),
        .plot_bullet (plot_bullet),
        .firing      (firing),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit plot;
        int x;
        int y;
        int col;
        bit fin;
    } exp_t;

    exp_t q[$];

    int checks   = 0;
    int failures = 0;

    // model state: what is on screen and what is waiting
    bit m_have;
    int m_px, m_py;
    bit m_pvalid;
    int m_qx, m_qy;
    bit m_erase;
    bit m_last_fire;
    bit fire_r;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic push_square(input int bx, input int by, input int col);
        exp_t e;
        for (int i = 0; i < SIZE * SIZE; i++) begin
            e.x   = bx + (i % SIZE);
            e.y   = by + (i / SIZE);
`ifdef BULLET_RENDER_CLIP_EN
            e.plot = (e.x < 160) && (e.y < 120);
`else
            e.plot = 1'b1;
`endif
            e.x   = e.x & 255;
            e.y   = e.y & 127;
            e.col = col;
            e.fin = 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic push_done();
        exp_t e;
        e.plot = 1'b0;
        e.x    = 0;
        e.y    = 0;
        e.col  = 0;
        e.fin  = 1'b1;
        q.push_back(e);
    endtask

    task automatic step(input bit pb, input int bx, input int by,
                        input bit fr);
        exp_t e;
        bit   idle;
        @(negedge clk);
        if (q.size() > 0) begin
            e    = q.pop_front();
            idle = 1'b0;
            check("busy", 32'(busy), 32'd1);
            check("done", 32'(done), 32'(e.fin));
            check("plot", 32'(vga_plot), 32'(e.plot));
            if (e.plot) begin
                check("vga_x", 32'(vga_x), 32'(e.x));
                check("vga_y", 32'(vga_y), 32'(e.y));
                check("colour", 32'(vga_colour), 32'(e.col));
            end
        end else begin
            idle = 1'b1;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_plot", 32'(vga_plot), 32'd0);
        end
        plot_bullet = pb;
        bullet_x    = 8'(bx);
        bullet_y    = 7'(by);
        firing      = fr;
        fire_r      = fr;
        if (idle) begin
            if (m_erase) begin
                m_erase = 1'b0;
                if (m_have) begin
                    push_square(m_px, m_py, 0);
                    push_done();
                    m_have = 1'b0;
                end
            end else if (m_pvalid) begin
                m_pvalid = 1'b0;
                if (m_have) push_square(m_px, m_py, 0);
                push_square(m_qx, m_qy, 7);
                push_done();
                m_px   = m_qx;
                m_py   = m_qy;
                m_have = 1'b1;
            end
        end
        if (pb) begin
            m_pvalid = 1'b1;
            m_qx     = bx;
            m_qy     = by;
        end
        if (m_last_fire && !fr) begin
            m_pvalid = 1'b0;
            m_erase  = 1'b1;
        end
        m_last_fire = fr;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, fire_r);
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        plot_bullet = 1'b0;
        q.delete();
        m_have      = 1'b0;
        m_pvalid    = 1'b0;
        m_erase     = 1'b0;
        m_last_fire = 1'b0;
        #1;
        check("rst_async_plot", 32'(vga_plot), 32'd0);
        @(negedge clk);
        check("rst_x", 32'(vga_x), 32'd0);
        check("rst_y", 32'(vga_y), 32'd0);
        check("rst_colour", 32'(vga_colour), 32'd0);
        check("rst_plot", 32'(vga_plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        resetn = 1'b1;
    endtask

    initial begin
        resetn      = 1'b0;
        bullet_x    = '0;
        bullet_y    = '0;
        plot_bullet = 1'b0;
        firing      = 1'b0;
        fire_r      = 1'b0;
        @(negedge clk);
        do_reset();
        idle_cycles(3);

        // first draw, then a move
        step(1'b1, 79, 59, 1'b1);
        idle_cycles(8);
        step(1'b1, 81, 59, 1'b1);
        idle_cycles(12);

        // firing falls: erase only; a second fall finds nothing to erase
        step(1'b0, 0, 0, 1'b0);
        idle_cycles(8);
        step(1'b0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b0);
        idle_cycles(6);

        // latest request wins while busy
        step(1'b1, 40, 40, 1'b1);
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 10, 10, 1'b1);
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 20, 20, 1'b1);
        step(1'b1, 30, 30, 1'b1);
        idle_cycles(25);

        // bottom-right corner: off-screen pixels
        step(1'b1, 159, 119, 1'b1);
        idle_cycles(12);

        // reset in the middle of the draw phase of a move
        step(1'b1, 50, 50, 1'b1);
        idle_cycles(6);
        do_reset();
        step(1'b1, 60, 60, 1'b1);
        idle_cycles(8);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            bit pb;
            int bx, by;
            bit fr;
            pb = ($urandom_range(0, 7) == 0);
            bx = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 159)
                                             : $urandom_range(0, 159);
            by = ($urandom_range(0, 3) == 0) ? $urandom_range(112, 119)
                                             : $urandom_range(0, 119);
            fr = fire_r;
            if ($urandom_range(0, 29) == 0) fr = ~fire_r;
            step(pb, bx, by, fr);
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        idle_cycles(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bullet_renderer.md
# bullet_renderer

Draw-side consumer of the bullet position stream. Each accepted position update from the bullet core (x, y, plot strobe) becomes a pixel-write sequence into the VGA adapter: the square sprite at the previous position is erased, then the sprite at the new position is drawn. When the bullet stops firing, its last image is erased. Sits between the bullet core and the shared VGA adapter write port, on the 160x120 frame.

## Interface
- SIZE, 2: sprite edge in pixels; legal range 1..4.
- FG_COLOUR, 3'b111: colour used to draw the bullet.
- BG_COLOUR, 3'b000: colour used to erase the bullet.
- clk  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  asynchronous, active-low reset.
- bullet_x  in  8  bullet column, 0..159.
- bullet_y  in  7  bullet row, 0..119.
- plot_bullet  in  1  one-cycle request: draw the bullet at bullet_x/bullet_y.
- firing  in  1  bullet alive; a high-to-low transition requests an erase.
- vga_x  out  8  pixel column to the VGA adapter.
- vga_y  out  7  pixel row to the VGA adapter.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  pixel write enable; one pixel per high cycle.
- busy  out  1  a sequence is in progress.
- done  out  1  one-cycle pulse when a sequence completes.

## Operation
- States: IDLE, ERASE, DRAW, FINISH.
- Stored state:
  - prev_x/prev_y: origin of the sprite currently on screen.
  - have_prev flag.
  - One-entry pending request: a coordinate pair plus a valid bit.
- Request capture, any state: plot_bullet captures bullet_x/bullet_y into the pending slot. A newer request overwrites an unserved one (latest wins).
- Erase request: the cycle where firing was high last cycle and is low now. It clears the pending slot and sets a pending-erase bit.
  - If it coincides with plot_bullet, the erase wins and the plot is discarded.
- Dispatch in IDLE, when pending-erase or the pending slot is valid:
  - Pending-erase with have_prev: go to ERASE with draw_after=0.
  - Pending-erase without have_prev: clear the bit and stay in IDLE. No done pulse.
  - Pending plot: latch the target coordinates and clear the slot. Go to ERASE if have_prev, otherwise go directly to DRAW. Set draw_after=1.
- ERASE:
  - Walk px,py over SIZE x SIZE, row-major (px fastest).
  - Output prev_x+px, prev_y+py with BG_COLOUR, one pixel per cycle.
  - After the last pixel: go to DRAW if draw_after, otherwise go to FINISH and clear have_prev.
- DRAW:
  - Same walk at target+px, target+py with FG_COLOUR.
  - After the last pixel: prev <= target, have_prev <= 1, go to FINISH.
- FINISH: assert done for one cycle, then return to IDLE. A pending item is dispatched on the next IDLE cycle.
- Arithmetic: coordinate sums are computed 1 bit wider than the port, then range-checked against 160/120 (see Configuration).

## Timing
- Reset values: vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, done=0. Internal reset: state IDLE, have_prev=0, pending cleared, firing history=0.
- Reset asserted mid-sequence aborts the sequence immediately. No vga_plot follows it.
- All outputs are registered.
- Dispatch at cycle T gives the first vga_plot at T+1. After that, one pixel per cycle with no gaps.
- busy is high from T+1 through the done cycle inclusive.
- Sequence length from first pixel to done (inclusive):
  - Move: 2*SIZE^2+1 cycles.
  - First draw: SIZE^2+1 cycles.
  - Erase-only: SIZE^2+1 cycles.
- plot_bullet is never back-pressured. At most one request is retained.

## Configuration
- BULLET_RENDER_CLIP_EN defined: a pixel whose sum is at x>=160 or y>=120 is suppressed. That cycle still elapses with vga_plot=0, so sequence length is unchanged.
- Not defined: every pixel asserts vga_plot, and coordinates are truncated to 8/7 bits.

## Test plan
- Reset, then plot_bullet at (79,59), SIZE=2 -> 4 writes in order (79,59),(80,59),(79,60),(80,60), colour 7; done on the 5th cycle after the first write.
- Then plot at (81,59) -> 4 writes of colour 0 at the 79/59 square, then 4 writes of colour 7 at the 81/59 square; busy high for 9 cycles.
- firing falls while idle with the sprite at (81,59) -> 4 writes of colour 0 only, then done. A following firing fall produces no writes.
- Three plot_bullet pulses during one busy sequence at (10,10),(20,20),(30,30) -> only (30,30) is drawn afterward.
- CLIP_EN defined, plot at (159,119) -> only (159,119) is written; vga_plot is low for the 3 off-screen slots; done timing unchanged.
- resetn low mid-DRAW -> vga_plot=0 next edge, busy=0. The next plot draws without an erase.
